// File: rtl/settable_timekeeper.sv
// HH:MM:SS timekeeper with debounced mode/inc/dec buttons, set-mode timeout and a blinking mode LED.
// Latency: a button press takes effect 2 + DEBOUNCE + 1 cycles after its raw edge; all outputs are registered.
// Backpressure: none; raw button levels are sampled every cycle and the outputs are free-running.
module settable_timekeeper #(
    parameter int TICK_DIV      = 10000,
    parameter int DEBOUNCE      = 4,
    parameter int HOURS_MOD     = 24,
    parameter int SET_TIMEOUT_S = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mode_btn,
    input  logic        inc_btn,
    input  logic        dec_btn,
    output logic [17:0] time_out,
    output logic [1:0]  mode,
    output logic        mode_led,
    output logic        sec_tick
);

    localparam int IDLE_LIMIT = SET_TIMEOUT_S * TICK_DIV;
    localparam int HALF_DIV   = TICK_DIV / 2;
    localparam int PS_W       = $clog2(TICK_DIV);
    localparam int DB_W       = $clog2(DEBOUNCE + 1);
    localparam int IDLE_W     = $clog2(IDLE_LIMIT);
    localparam int BL_W       = $clog2(HALF_DIV);

    localparam logic [PS_W-1:0]   PS_LAST   = PS_W'(TICK_DIV - 1);
    localparam logic [PS_W-1:0]   PS_ONE    = PS_W'(1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE - 1);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_LIMIT - 1);
    localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
    localparam logic [BL_W-1:0]   BL_LAST   = BL_W'(HALF_DIV - 1);
    localparam logic [BL_W-1:0]   BL_ONE    = BL_W'(1);
    localparam logic [5:0]        MS_LAST   = 6'd59;
    localparam logic [5:0]        HR_LAST   = 6'(HOURS_MOD - 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_SEC = 2'd1,
        SET_MIN = 2'd2,
        SET_HR  = 2'd3
    } mode_t;

    function automatic logic [5:0] step_up(input logic [5:0] v, input logic [5:0] last);
        return (v == last) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [5:0] step_down(input logic [5:0] v, input logic [5:0] last);
        return (v == 6'd0) ? last : v - 6'd1;
    endfunction

    // Button path, bit order {dec, inc, mode}: sync, debounce, rising-edge press pulse
    logic [2:0]      raw, sync1, sync2, level, press;
    logic [DB_W-1:0] db_cnt [3];

    assign raw = {dec_btn, inc_btn, mode_btn};

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            level <= '0;
            press <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 3; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_cnt[i] <= '0;
                    level[i]  <= sync2[i];
                    press[i]  <= sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_ONE;
                end
            end
        end
    end

    logic mode_p, inc_p, dec_p, any_press, edit_inc, edit_dec;
    assign mode_p    = press[0];
    assign inc_p     = press[1];
    assign dec_p     = press[2];
    assign any_press = |press;

    mode_t             mode_q, mode_nxt;
    logic [PS_W-1:0]   presc_q;
    logic [IDLE_W-1:0] idle_q;
    logic [BL_W-1:0]   blink_q;
    logic [5:0]        sec_q, min_q, hr_q;
    logic              tick, timeout;

    // Simultaneous inc and dec cancel; edits use the mode held before any transition
    assign edit_inc = inc_p & ~dec_p & (mode_q != RUN);
    assign edit_dec = dec_p & ~inc_p & (mode_q != RUN);

    always_comb begin
        tick     = (mode_q == RUN) && (presc_q == PS_LAST);
        timeout  = (mode_q != RUN) && !any_press && (idle_q == IDLE_LAST);
        mode_nxt = mode_q;
        if (mode_p) begin
            case (mode_q)
                RUN:     mode_nxt = SET_SEC;
                SET_SEC: mode_nxt = SET_MIN;
                SET_MIN: mode_nxt = SET_HR;
                default: mode_nxt = RUN;
            endcase
        end else if (timeout) begin
            mode_nxt = RUN;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) mode_q <= RUN;
        else       mode_q <= mode_nxt;
    end

    always_ff @(posedge clock) begin
        if (reset || mode_q != RUN || tick) presc_q <= '0;
        else                                presc_q <= presc_q + PS_ONE;

        if (reset || mode_q == RUN || any_press || mode_nxt != mode_q) idle_q <= '0;
        else                                                         idle_q <= idle_q + IDLE_ONE;

        sec_tick <= !reset && tick;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            blink_q  <= '0;
            mode_led <= 1'b0;
        end else if (mode_nxt != mode_q) begin
            blink_q  <= '0;
            mode_led <= (mode_nxt != RUN);
        end else if (mode_q == RUN) begin
            blink_q  <= '0;
            mode_led <= 1'b0;
        end else if (blink_q == BL_LAST) begin
            blink_q  <= '0;
            mode_led <= ~mode_led;
        end else begin
            blink_q  <= blink_q + BL_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sec_q <= '0;
            min_q <= '0;
            hr_q  <= '0;
        end else if (tick) begin
            sec_q <= step_up(sec_q, MS_LAST);
            if (sec_q == MS_LAST) begin
                min_q <= step_up(min_q, MS_LAST);
                if (min_q == MS_LAST) hr_q <= step_up(hr_q, HR_LAST);
            end
        end else if (edit_inc || edit_dec) begin
            case (mode_q)
                SET_SEC: sec_q <= edit_inc ? step_up(sec_q, MS_LAST) : step_down(sec_q, MS_LAST);
                SET_MIN: min_q <= edit_inc ? step_up(min_q, MS_LAST) : step_down(min_q, MS_LAST);
                SET_HR:  hr_q  <= edit_inc ? step_up(hr_q, HR_LAST)  : step_down(hr_q, HR_LAST);
                default: ;
            endcase
        end
    end

    assign time_out = {hr_q, min_q, sec_q};
    assign mode     = mode_q;

endmodule
